// File: rtl/ah_arb_pkg.sv
// ah_arb_pkg: shared arbiter constants and the buffered grant entry type
package ah_arb_pkg;
    localparam int NREQ  = 8;
    localparam int SRC_W = 3;
    localparam int DW    = 32;
    typedef struct packed {
        logic [SRC_W-1:0] src;
        logic [DW-1:0]    data;
    } entry_t;
endpackage

// File: rtl/ah_gpm_fifo2.sv
// ah_gpm_fifo2: 2-entry FIFO with occupancy count; caller guarantees no overflow/underflow
module ah_gpm_fifo2 #(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_cnt;

    // storage is not reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wptr] <= din;
    end

    // pointers wrap modulo 2; simultaneous push and pop keeps the count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (push) r_wptr <= ~r_wptr;
            if (pop)  r_rptr <= ~r_rptr;
            r_cnt <= r_cnt + 2'(push) - 2'(pop);
        end
    end

    assign dout  = r_mem[r_rptr];
    assign count = r_cnt;
endmodule

// File: rtl/ah_grant_payload_mux.sv
// ah_grant_payload_mux: captures the granted requester's payload into a 2-entry buffer; AH_GPM_STATS_EN adds drop_cnt
module ah_grant_payload_mux
    import ah_arb_pkg::SRC_W;
#(
    parameter int NREQ = 8,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    grant,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_pop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [SRC_W-1:0]   out_src,
    output logic               onehot_err,
`ifdef AH_GPM_STATS_EN
    output logic [7:0]         drop_cnt,
`endif
    output logic               drop
);
    logic             w_nonzero;
    logic             w_onehot;
    logic [SRC_W-1:0] w_idx;
    logic             w_deq;
    logic             w_space;
    logic             w_push;
    logic [1:0]       w_count;

    assign w_nonzero = grant != '0;
    assign w_onehot  = w_nonzero && ((grant & (grant - NREQ'(1))) == '0);

    // priority encoder; only meaningful when the grant is one-hot
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i]) w_idx = SRC_W'(i);
    end

    assign out_valid  = w_count != 2'd0;
    assign w_deq      = out_valid && out_ready;
    assign w_space    = (w_count < 2'd2) || w_deq;
    assign w_push     = !rst && w_onehot && w_space;
    assign req_pop    = w_push ? grant : '0;
    assign drop       = !rst && w_onehot && !w_space;
    assign onehot_err = !rst && w_nonzero && !w_onehot;

    ah_gpm_fifo2 #(.W(SRC_W + DW)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (w_push),
        .pop  (w_deq),
        .din  ({w_idx, req_data[int'(w_idx)*DW +: DW]}),
        .dout ({out_src, out_data}),
        .count(w_count)
    );

`ifdef AH_GPM_STATS_EN
    logic [7:0] r_drop_cnt;

    // saturating count of lost grants
    always_ff @(posedge clk) begin
        if (rst) r_drop_cnt <= 8'd0;
        else if (drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign drop_cnt = r_drop_cnt;
`endif
endmodule

// File: tb/tb_ah_grant_payload_mux.sv
// tb_ah_grant_payload_mux: directed and random checks against a queue model; AH_GPM_STATS_EN enables drop_cnt checks
module tb_ah_grant_payload_mux;
    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   grant;
    logic [255:0] req_data;
    logic [7:0]   req_pop;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [2:0]   out_src;
    logic         onehot_err;
    logic         drop;
`ifdef AH_GPM_STATS_EN
    logic [7:0]   drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [34:0] q[$];
    int m_drop = 0;
    logic [7:0] last_pop;
    logic last_drop, last_err;

    ah_grant_payload_mux dut (
        .clk(clk), .rst(rst), .grant(grant), .req_data(req_data), .req_pop(req_pop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
        .onehot_err(onehot_err),
`ifdef AH_GPM_STATS_EN
        .drop_cnt(drop_cnt),
`endif
        .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rnd_data();
        for (int i = 0; i < 8; i++) req_data[i*32 +: 32] = $urandom;
    endtask

    task automatic cyc(input logic [7:0] g, input logic rdy, input logic r);
        logic one, deq, space, psh;
        int idx;
        grant = g; out_ready = rdy; rst = r;
        #1;
        one   = $countones(g) == 1;
        deq   = q.size() != 0 && rdy;
        space = q.size() < 2 || deq;
        psh   = !r && one && space;
        idx   = one ? $clog2(g) : 0;
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0][31:0]);
            chk("out_src", out_src, q[0][34:32]);
        end
        chk("req_pop", req_pop, psh ? g : 8'h00);
        chk("drop", drop, !r && one && !space);
        chk("onehot_err", onehot_err, !r && g != 0 && !one);
`ifdef AH_GPM_STATS_EN
        chk("drop_cnt", drop_cnt, m_drop);
`endif
        last_pop = req_pop; last_drop = drop; last_err = onehot_err;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_drop = 0;
        end else begin
            if (deq) void'(q.pop_front());
            if (psh) q.push_back({3'(idx), req_data[idx*32 +: 32]});
            if (one && !space && m_drop < 255) m_drop++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; grant = '0; out_ready = 1'b0; req_data = '0;
        @(posedge clk);
        @(negedge clk);
        cyc(8'h00, 1'b0, 1'b1);
        chk("rst_valid", out_valid, 1'b0);

        rnd_data();
        req_data[2*32 +: 32] = 32'hA5A5_0002;
        cyc(8'h04, 1'b1, 1'b0);
        chk("r035_pop", last_pop, 8'h04);
        chk("r035_valid", out_valid, 1'b1);
        chk("r035_data", out_data, 32'hA5A5_0002);
        chk("r035_src", out_src, 3'd2);
        cyc(8'h00, 1'b1, 1'b0);

        rnd_data();
        cyc(8'h01, 1'b0, 1'b0);
        chk("r036_pop0", last_pop, 8'h01);
        cyc(8'h80, 1'b0, 1'b0);
        chk("r036_pop7", last_pop, 8'h80);
        cyc(8'h10, 1'b0, 1'b0);
        chk("r036_drop", last_drop, 1'b1);
        chk("r036_nopop", last_pop, 8'h00);
        chk("r036_head0", out_src, 3'd0);
        cyc(8'h00, 1'b1, 1'b0);
        chk("r036_head7", out_src, 3'd7);
        cyc(8'h00, 1'b1, 1'b0);
        chk("r036_empty", out_valid, 1'b0);

        cyc(8'h02, 1'b0, 1'b0);
        cyc(8'h05, 1'b0, 1'b0);
        chk("r037_err", last_err, 1'b1);
        chk("r037_nopop", last_pop, 8'h00);
        chk("r037_valid", out_valid, 1'b1);
        cyc(8'h00, 1'b0, 1'b0);
        chk("r037_pulse", last_err, 1'b0);

        cyc(8'h08, 1'b0, 1'b0);
        rnd_data();
        cyc(8'h02, 1'b1, 1'b0);
        chk("r038_pop", last_pop, 8'h02);
        chk("r038_nodrop", last_drop, 1'b0);
        chk("r038_head", out_src, 3'd3);
        cyc(8'h04, 1'b0, 1'b0);
        chk("r038_full", last_drop, 1'b1);

        cyc(8'h00, 1'b1, 1'b0);
        chk("r039_one", out_valid, 1'b1);
        cyc(8'h01, 1'b1, 1'b1);
        chk("r039_nopop", last_pop, 8'h00);
        chk("r039_valid", out_valid, 1'b0);

        for (int n = 0; n < 400; n++) begin
            int k, a, b;
            logic [7:0] g;
            rnd_data();
            k = $urandom_range(0, 9);
            a = $urandom_range(0, 7);
            b = (a + 1 + $urandom_range(0, 6)) % 8;
            g = k < 3 ? 8'h00 : k < 8 ? 8'(1 << a) : 8'((1 << a) | (1 << b));
            cyc(g, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
        end

`ifdef AH_GPM_STATS_EN
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h01, 1'b0, 1'b0);
        cyc(8'h02, 1'b0, 1'b0);
        repeat (300) cyc(8'h40, 1'b0, 1'b0);
        chk("r040_sat", drop_cnt, 8'hFF);
        cyc(8'h00, 1'b0, 1'b1);
        chk("r040_clr", drop_cnt, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
